// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, default parameters and parity helper.
// Used by both the receive and transmit sides of the UART.
package uart_pkg;

  localparam int UART_DW_DEF  = 8;
  localparam int UART_CPB_DEF = 16;
  localparam int UART_MAX_DW  = 64;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  // Even-parity bit for up to UART_MAX_DW data bits (zero-extend narrower words).
  function automatic logic even_parity(
    input logic [UART_MAX_DW-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and status strobes out.
// slave = receiver side, master = pad/consumer side.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DW = UART_DW_DEF
);

  logic          rx_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          frame_err_o;
  logic          parity_err_o;
  logic          busy_o;

  modport slave (
    input  rx_i,
    output data_o,
    output valid_o,
    output frame_err_o,
    output parity_err_o,
    output busy_o
  );

  modport master (
    output rx_i,
    input  data_o,
    input  valid_o,
    input  frame_err_o,
    input  parity_err_o,
    input  busy_o
  );

endinterface

// File: rtl/sipo_shift_register.sv
// sipo_shift_register: serial-in/parallel-out, right shift, serial bit
// enters the MSB so the first bit received ends up in bit 0.
module sipo_shift_register #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          shift_i,
  input  logic          serial_i,
  input  logic          clear_i,
  output logic [DW-1:0] data_o
);

  logic [DW-1:0] sr_q;
  logic [DW-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clear_i) begin
      sr_d = '0;
    end else if (shift_i) begin
      sr_d = (sr_q >> 1) | (DW'(serial_i) << (DW - 1));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign data_o = sr_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 1 start, DW data LSB first, optional even
// parity (UART_RX_PARITY_EN), 1 stop; registered one-cycle strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DW           = UART_DW_DEF,
  parameter int CLKS_PER_BIT = UART_CPB_DEF
) (
  input  logic     clk_i,
  input  logic     rst_i,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(DW - 1);

  logic           sync1_q;
  logic           rx_s_q;
  logic           prev_q;
  uart_rx_state_e state_q;
  uart_rx_state_e state_d;
  logic [CW-1:0]  clk_cnt_q;
  logic [CW-1:0]  clk_cnt_d;
  logic [BW-1:0]  bit_cnt_q;
  logic [BW-1:0]  bit_cnt_d;
  logic [DW-1:0]  data_q;
  logic [DW-1:0]  data_d;
  logic [DW-1:0]  sr_data;
  logic           valid_q;
  logic           valid_d;
  logic           ferr_q;
  logic           ferr_d;
  logic           shift;
  logic           clear;
  logic           fall;
  logic           tick_half;
  logic           tick_full;
  logic           par_bad;

  assign fall      = prev_q & ~rx_s_q;
  assign tick_half = (clk_cnt_q == HALF);
  assign tick_full = (clk_cnt_q == FULL);

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic par_d;
  logic perr_q;
  logic perr_d;

  assign par_bad = even_parity(UART_MAX_DW'(sr_data)) ^ par_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign bus.parity_err_o = perr_q;
`else
  assign par_bad          = 1'b0;
  assign bus.parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= bus.rx_i;
      rx_s_q    <= sync1_q;
      prev_q    <= rx_s_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fall) state_d = START;
      end
      START: begin
        if (tick_half) state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: begin
        if (tick_full && bit_cnt_q == LAST) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_full) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    shift     = 1'b0;
    clear     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        clear     = fall;
      end
      START: begin
        if (tick_half) clk_cnt_d = '0;
      end
      DATA: begin
        if (tick_full) begin
          clk_cnt_d = '0;
          shift     = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_full) begin
          clk_cnt_d = '0;
          par_d     = rx_s_q;
        end
      end
`endif
      STOP: begin
        if (tick_full) begin
          clk_cnt_d = '0;
          // Framing error outranks parity; only a clean frame updates data.
          if (!rx_s_q) begin
            ferr_d = 1'b1;
          end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
            perr_d = 1'b1;
`endif
          end else begin
            data_d  = sr_data;
            valid_d = 1'b1;
          end
        end
      end
      default: clk_cnt_d = '0;
    endcase
  end

  sipo_shift_register #(
    .DW(DW)
  ) u_sipo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .shift_i (shift),
    .serial_i(rx_s_q),
    .clear_i (clear),
    .data_o  (sr_data)
  );

  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.frame_err_o = ferr_q;
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: recovers frames from the asynchronous serial line and presents each received byte as a parallel word with a one-cycle valid strobe. It is the receive-side counterpart of the UART transmitter's parallel-in/serial-out datapath. Frame format is one start bit, DW data bits sent LSB first, optionally one even-parity bit, and one stop bit. The block sits between the RX pad and the byte consumer, and all outputs are registered in the clk_i domain.

## Interface
- DW, 8: data bits per frame, ≥1.
- CLKS_PER_BIT, 16: clk_i cycles per bit period, even, ≥4.
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- rx_i  in  1  serial line, asynchronous to clk_i, idle high.
- data_o  out  DW  last good byte, LSB = first data bit received.
- valid_o  out  1  one-cycle pulse; data_o holds a new byte.
- frame_err_o  out  1  one-cycle pulse; stop bit sampled low.
- parity_err_o  out  1  one-cycle pulse; even-parity mismatch.
- busy_o  out  1  high in every state except IDLE.

## Operation
- Reset values:
  - data_o = 0; valid_o, frame_err_o, parity_err_o, busy_o = 0.
  - Both synchronizer flops and the previous-sample flop = 1.
  - State = IDLE; bit counter = 0; clock counter = 0.
- rx_i passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE:
  - A falling edge on rx_s (previous 1, current 0) moves to START and clears the clock counter.
  - A line held low never starts a frame. A break is reported once, then ignored until the line returns high.
- START:
  - Sample rx_s when the counter reaches CLKS_PER_BIT/2−1, i.e. mid start bit.
  - rx_s = 0: go to DATA, counter = 0.
  - rx_s = 1: treat as a glitch. Return to IDLE with no pulse.
- DATA:
  - Sample when the counter reaches CLKS_PER_BIT−1, then shift the bit into the sub-module and restart the counter.
  - After DW samples, go to PARITY if present, otherwise STOP.
- PARITY: sample at CLKS_PER_BIT−1, store the parity bit, go to STOP.
- STOP: sample at CLKS_PER_BIT−1, then go to IDLE. Exactly one outcome per frame, with priority:
  - rx_s = 0 → frame_err_o pulse; data_o unchanged.
  - Parity mismatch → parity_err_o pulse; data_o unchanged.
  - Otherwise → data_o loaded and valid_o pulses.
- Because the block returns to IDLE at mid stop bit, a back-to-back frame's start edge is caught.
- rst_i mid-frame aborts immediately. No pulse is produced and partial data is discarded.

## Timing
- Let C = CLKS_PER_BIT, and let edge 0 be the clock edge at which IDLE detects the falling edge of rx_s.
- rx_s lags rx_i by 2 clock edges.
- Sample edges after edge 0:
  - Start bit: C/2.
  - Data bit k (k = 0..DW−1): C/2 + (k+1)·C.
  - Parity bit: C/2 + (DW+1)·C.
  - Stop bit: C/2 + (DW+1)·C without parity; C/2 + (DW+2)·C with parity.
- valid_o, frame_err_o, parity_err_o and data_o update on the stop-sample edge and are high for exactly one cycle.
- busy_o rises on edge 0 and falls on the stop-sample edge.
- Tolerated baud mismatch: ±(C/2−1)/C over a full frame. This is the transmitter's responsibility.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state is present; the frame carries DW+3 bits.
  - Even parity is enforced: XOR of the data bits and the parity bit must be 0.
- Undefined:
  - PARITY state is not compiled; the frame carries DW+2 bits.
  - The parity_err_o port remains and is tied to 0.

## Structure
- uart_pkg:
  - uart_rx_state_e enum.
  - Default-parameter constants.
  - Even-parity helper function shared with the transmitter.
- Sub-module sipo_shift_register #(DW), the serial-in/parallel-out dual of the transmit shift register:
  - Inputs: clk_i, rst_i, shift_i, serial_i, clear_i.
  - Output: data_o.
  - Right shift with serial_i entering the MSB, so after DW shifts bit 0 is the first bit received.

## Test plan
All scenarios use DW=8 and C=16.
- Frame 0xA5 with a valid stop bit → valid_o for one cycle at edge 8+9·16=152 after detection, data_o = 0xA5, busy_o low afterwards.
- 0x00 followed immediately by 0xFF, with no idle gap → two valid_o pulses 160 cycles apart; data_o = 0x00, then 0xFF.
- 0x3C with the stop bit driven 0 → frame_err_o pulse, no valid_o; data_o retains its previous value. rx_i held low for 500 cycles produces no further pulses.
- rx_i low pulse of 4 cycles → no pulses; busy_o returns low at edge 8.
- rst_i asserted during data bit 3 of 0x5A → all outputs 0 immediately; the next 0x81 frame is received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 (mismatch) → parity_err_o only. 0x07 with parity bit 1 → valid_o at edge 168.
